// File: rtl/aes192_ctrl.sv
`timescale 1ns/1ps
// aes192_ctrl: sequences AES-192 key expansion and the column-serial round datapath, arbitrating the shared S-box bank.
// Latency: READY 9 cycles after the last i_key_en; o_dout_en pulses 4*NR+1 cycles after o_load.
// Backpressure: o_din_ready low outside READY or while i_key_en is high; i_din_en without o_din_ready is dropped.
module aes192_ctrl #(
    // Number of rounds; legal values are 10, 12 and 14 (round counter is 4 bits).
    parameter int unsigned NR = 12
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_key_en,
    output logic        o_kx_key_en,
    input  logic        i_kx_key_ok,
    input  logic        i_kx_sbox_use,
    input  logic [31:0] i_kx_sbox_din,
    input  logic [31:0] i_rd_sbox_din,
    output logic [31:0] o_sbox_din,
    input  logic        i_din_en,
    output logic        o_din_ready,
    output logic        o_load,
    output logic [3:0]  o_round,
    output logic [1:0]  o_col,
    output logic        o_round_end,
    output logic        o_last_round,
    output logic        o_dout_en,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_KEYEX = 2'd1,
        S_READY = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [1:0] col_q, col_d;
    logic       dout_en_q, dout_en_d;
    logic       run;

    // Key load goes straight through to keyex; the S-box bank gives key expansion priority.
    always_comb begin
        o_kx_key_en = i_key_en;
        o_sbox_din  = i_kx_sbox_use ? i_kx_sbox_din : i_rd_sbox_din;
    end

    // Status and handshake outputs decoded from the registered state.
    always_comb begin
        run          = (state_q == S_RUN);
        o_din_ready  = (state_q == S_READY) & ~i_key_en;
        o_load       = i_din_en & o_din_ready;
        o_round      = run ? round_q : 4'd0;
        o_col        = run ? col_q : 2'd0;
        o_round_end  = run & (col_q == 2'd3);
        o_last_round = run & (round_q == LAST_ROUND);
        o_dout_en    = dout_en_q;
        o_busy       = (state_q == S_KEYEX) | run;
    end

    // Next-state: a key load overrides everything and abandons any block in flight.
    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        col_d     = col_q;
        dout_en_d = 1'b0;
        if (i_key_en) begin
            state_d = S_KEYEX;
            round_d = 4'd0;
            col_d   = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_KEYEX: begin
                    if (i_kx_key_ok) begin
                        state_d = S_READY;
                    end
                end
                S_READY: begin
                    if (o_load) begin
                        state_d = S_RUN;
                        round_d = 4'd1;
                        col_d   = 2'd0;
                    end
                end
                S_RUN: begin
                    if (col_q == 2'd3) begin
                        col_d = 2'd0;
                        if (round_q == LAST_ROUND) begin
                            state_d   = S_READY;
                            round_d   = 4'd0;
                            dout_en_d = 1'b1;
                        end else begin
                            round_d = round_q + 4'd1;
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    round_d = 4'd0;
                    col_d   = 2'd0;
                end
            endcase
        end
    end

    // State, round/column counters and the one-cycle ciphertext-valid flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            round_q   <= 4'd0;
            col_q     <= 2'd0;
            dout_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            col_q     <= col_d;
            dout_en_q <= dout_en_d;
        end
    end

endmodule

// File: tb/tb_aes192_ctrl.sv
`timescale 1ns/1ps
// Bench for aes192_ctrl: wraps it with a keyex stub and a column-serial AES-192 datapath
// that uses the shared S-box path, and checks timing and ciphertexts against a one-shot AES-192 model.
module tb_aes192_ctrl;

    localparam logic [191:0] FIPS_KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_en = 1'b0;
    logic        din_en = 1'b0;
    logic        rd_fixed = 1'b0;
    logic [31:0] kx_din = 32'h0;
    logic [31:0] rd_din;
    logic        kx_use;
    logic        kx_ok;
    logic [2:0]  kx_cnt;
    logic [191:0] key_in = 192'h0;
    logic [127:0] pt_in = 128'h0;
    logic [1663:0] ks_cur;
    logic [127:0] dp_st = 128'h0;
    logic [127:0] sub_st = 128'h0;
    logic [127:0] ct_q[$];
    int cyc = 0;
    int total = 0;
    int bad = 0;

    logic        o_kx_key_en, o_din_ready, o_load, o_round_end, o_last_round, o_dout_en, o_busy;
    logic [31:0] o_sbox_din;
    logic [3:0]  o_round;
    logic [1:0]  o_col;

    aes192_ctrl #(.NR(12)) dut (
        .i_clk(clk), .i_rst(rst), .i_key_en(key_en), .o_kx_key_en(o_kx_key_en),
        .i_kx_key_ok(kx_ok), .i_kx_sbox_use(kx_use), .i_kx_sbox_din(kx_din),
        .i_rd_sbox_din(rd_din), .o_sbox_din(o_sbox_din), .i_din_en(din_en),
        .o_din_ready(o_din_ready), .o_load(o_load), .o_round(o_round), .o_col(o_col),
        .o_round_end(o_round_end), .o_last_round(o_last_round), .o_dout_en(o_dout_en),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AES-192 reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t = {v, v} << n;
        return t[15:8];
    endfunction

    // Multiplicative inverse as x^254, then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        logic [7:0] p = x;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub32(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [1663:0] key_expand(input logic [191:0] k);
        logic [31:0] w[52];
        logic [31:0] t;
        logic [7:0] rc = 8'h01;
        logic [1663:0] ks;
        for (int i = 0; i < 6; i++) w[i] = k[191 - 32*i -: 32];
        for (int i = 6; i < 52; i++) begin
            t = w[i-1];
            if (i % 6 == 0) begin
                t = sub32({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-6] ^ t;
        end
        for (int i = 0; i < 52; i++) ks[1663 - 32*i -: 32] = w[i];
        return ks;
    endfunction

    function automatic logic [127:0] rk(input logic [1663:0] ks, input int r);
        return ks[1663 - 128*r -: 128];
    endfunction

    function automatic logic [31:0] get_col(input logic [127:0] s, input int c);
        return s[127 - 32*c -: 32];
    endfunction

    function automatic logic [127:0] set_col(input logic [127:0] s, input int c, input logic [31:0] w);
        s[127 - 32*c -: 32] = w;
        return s;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = get_col(s, c);
            o = set_col(o, c, {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                               xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)});
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [1663:0] ks, input logic [127:0] pt);
        logic [127:0] s = pt ^ rk(ks, 0);
        for (int r = 1; r <= 12; r++) begin
            for (int c = 0; c < 4; c++) s = set_col(s, c, sub32(get_col(s, c)));
            s = shift_rows(s);
            if (r != 12) s = mix_cols(s);
            s = s ^ rk(ks, r);
        end
        return s;
    endfunction

    // ---------------- keyex stub: owns the S-box T..T+7, key_ok at T+8 ----------------
    assign kx_use = key_en | (kx_cnt != 3'd0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            kx_cnt <= 3'd0;
            kx_ok  <= 1'b0;
        end else if (key_en) begin
            kx_cnt <= 3'd7;
            kx_ok  <= 1'b0;
            ks_cur <= key_expand(key_in);
        end else if (kx_cnt != 3'd0) begin
            kx_cnt <= kx_cnt - 3'd1;
            if (kx_cnt == 3'd1) kx_ok <= 1'b1;
        end
    end

    // ---------------- column-serial round datapath driven by the DUT ----------------
    assign rd_din = rd_fixed ? 32'h0000_5A5A : get_col(dp_st, int'(o_col));

    initial begin : datapath
        logic [127:0] s;
        forever begin
            @(negedge clk);
            if (o_dout_en === 1'b1) ct_q.push_back(dp_st);
            if (o_load === 1'b1) dp_st = pt_in ^ rk(ks_cur, 0);
            if (o_round !== 4'd0) begin
                sub_st = set_col(sub_st, int'(o_col), sub32(o_sbox_din));
                if (o_round_end === 1'b1) begin
                    s = shift_rows(sub_st);
                    if (o_last_round !== 1'b1) s = mix_cols(s);
                    dp_st = s ^ rk(ks_cur, int'(o_round));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        din_en = 1'b1;
        look();
        total++;
        if ({o_busy, o_din_ready, o_load, o_round_end, o_last_round, o_dout_en} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000000", {o_busy, o_din_ready, o_load, o_round_end, o_last_round, o_dout_en});
        end
        total++;
        if ({o_round, o_col} !== 6'b0) begin
            bad++;
            $display("FAIL reset_round_col: got %h want 00", {o_round, o_col});
        end
        for (int i = 0; i < 16; i++) begin
            step();
            rst = 1'b0;
            look();
            total++;
            if ({o_din_ready, o_load, o_busy} !== 3'b000) begin
                bad++;
                $display("FAIL idle_no_key i=%0d: got rdy/load/busy=%b want 000", i, {o_din_ready, o_load, o_busy});
            end
        end
        din_en = 1'b0;
    endtask

    task automatic test_keyload(input logic [191:0] k);
        rd_fixed = 1'b1;
        kx_din = 32'hA5A5_0000;
        step();
        key_en = 1'b1;
        key_in = k;
        look();
        total++;
        if (o_kx_key_en !== 1'b1 || o_sbox_din !== 32'hA5A5_0000) begin
            bad++;
            $display("FAIL key_t0: got kx_en=%b sbox=%h want 1 a5a50000", o_kx_key_en, o_sbox_din);
        end
        for (int k2 = 1; k2 <= 12; k2++) begin
            step();
            key_en = 1'b0;
            look();
            total++;
            if (o_busy !== (k2 <= 8) || o_din_ready !== (k2 >= 9)) begin
                bad++;
                $display("FAIL key_timing T+%0d: got busy=%b rdy=%b want %b %b", k2, o_busy, o_din_ready, k2 <= 8, k2 >= 9);
            end
            total++;
            if (o_sbox_din !== ((k2 <= 7) ? 32'hA5A5_0000 : 32'h0000_5A5A)) begin
                bad++;
                $display("FAIL key_sbox_mux T+%0d: got %h want %h", k2, o_sbox_din, (k2 <= 7) ? 32'hA5A5_0000 : 32'h0000_5A5A);
            end
        end
        rd_fixed = 1'b0;
        kx_din = $urandom;
    endtask

    task automatic test_fips();
        int er, ec, n_end, n_last;
        logic [127:0] got;
        n_end = 0;
        n_last = 0;
        step();
        din_en = 1'b1;
        pt_in = FIPS_PT;
        look();
        total++;
        if (o_load !== 1'b1) begin
            bad++;
            $display("FAIL fips_load: got %b want 1", o_load);
        end
        for (int k = 1; k <= 49; k++) begin
            step();
            din_en = 1'b0;
            look();
            er = (k <= 48) ? (k - 1) / 4 + 1 : 0;
            ec = (k <= 48) ? (k - 1) % 4 : 0;
            total++;
            if (o_round !== 4'(er) || o_col !== 2'(ec)) begin
                bad++;
                $display("FAIL fips_round_col D+%0d: got r%0d c%0d want r%0d c%0d", k, o_round, o_col, er, ec);
            end
            total++;
            if (o_dout_en !== (k == 49) || o_busy !== (k <= 48) || o_din_ready !== (k == 49)) begin
                bad++;
                $display("FAIL fips_status D+%0d: got dout/busy/rdy=%b%b%b want %b%b%b", k,
                         o_dout_en, o_busy, o_din_ready, k == 49, k <= 48, k == 49);
            end
            total++;
            if (o_last_round !== (er == 12)) begin
                bad++;
                $display("FAIL fips_last_round D+%0d: got %b want %b", k, o_last_round, er == 12);
            end
            if (o_round_end === 1'b1) n_end++;
            if (o_last_round === 1'b1) n_last++;
        end
        total++;
        if (n_end != 12 || n_last != 4) begin
            bad++;
            $display("FAIL fips_pulse_counts: got round_end=%0d last=%0d want 12 4", n_end, n_last);
        end
        total++;
        if (ct_q.size() != 1) begin
            bad++;
            $display("FAIL fips_ct_count: got %0d want 1", ct_q.size());
        end else begin
            got = ct_q.pop_front();
            if (got !== FIPS_CT) begin
                bad++;
                $display("FAIL fips_ct: got %h want %h", got, FIPS_CT);
            end
        end
        ct_q.delete();
    endtask

    task automatic test_back_to_back(input logic [191:0] k);
        logic [127:0] pa, pb, got;
        logic [1663:0] ks;
        ks = key_expand(k);
        pa = {$urandom, $urandom, $urandom, $urandom};
        pb = {$urandom, $urandom, $urandom, $urandom};
        step();
        din_en = 1'b1;
        pt_in = pa;
        look();
        for (int i = 1; i <= 48; i++) begin
            step();
            din_en = 1'b0;
            look();
        end
        step();
        din_en = 1'b1;
        pt_in = pb;
        look();
        total++;
        if (o_dout_en !== 1'b1 || o_load !== 1'b1) begin
            bad++;
            $display("FAIL b2b_overlap: got dout=%b load=%b want 1 1", o_dout_en, o_load);
        end
        for (int i = 1; i <= 49; i++) begin
            step();
            din_en = 1'b0;
            look();
            total++;
            if (o_dout_en !== (i == 49)) begin
                bad++;
                $display("FAIL b2b_dout D+%0d: got %b want %b", i, o_dout_en, i == 49);
            end
        end
        total++;
        if (ct_q.size() != 2) begin
            bad++;
            $display("FAIL b2b_ct_count: got %0d want 2", ct_q.size());
        end else begin
            got = ct_q.pop_front();
            if (got !== aes_encrypt(ks, pa)) begin
                bad++;
                $display("FAIL b2b_ct_a: got %h want %h", got, aes_encrypt(ks, pa));
            end
            total++;
            got = ct_q.pop_front();
            if (got !== aes_encrypt(ks, pb)) begin
                bad++;
                $display("FAIL b2b_ct_b: got %h want %h", got, aes_encrypt(ks, pb));
            end
        end
        ct_q.delete();
    endtask

    task automatic test_random(input logic [191:0] k);
        logic [1663:0] ks;
        logic [127:0] exp_ct[$];
        logic [127:0] got, want;
        int due[$];
        int next_rdy;
        logic exp_load, exp_dout;
        ks = key_expand(k);
        next_rdy = 0;
        for (int i = 0; i < 800; i++) begin
            step();
            din_en = (i < 700) && ($urandom_range(0, 3) == 0);
            pt_in = {$urandom, $urandom, $urandom, $urandom};
            look();
            exp_load = din_en && (cyc >= next_rdy);
            total++;
            if (o_load !== exp_load) begin
                bad++;
                $display("FAIL rand_load cyc=%0d: got %b want %b", cyc, o_load, exp_load);
            end
            if (exp_load) begin
                next_rdy = cyc + 49;
                due.push_back(cyc + 49);
                exp_ct.push_back(aes_encrypt(ks, pt_in));
            end
            exp_dout = (due.size() > 0) && (due[0] == cyc);
            total++;
            if (o_dout_en !== exp_dout) begin
                bad++;
                $display("FAIL rand_dout cyc=%0d: got %b want %b", cyc, o_dout_en, exp_dout);
            end
            if (exp_dout) begin
                void'(due.pop_front());
                want = exp_ct.pop_front();
                if (o_dout_en === 1'b1 && ct_q.size() > 0) begin
                    got = ct_q.pop_front();
                    total++;
                    if (got !== want) begin
                        bad++;
                        $display("FAIL rand_ct cyc=%0d: got %h want %h", cyc, got, want);
                    end
                end
            end
        end
        din_en = 1'b0;
        ct_q.delete();
    endtask

    task automatic test_abort(input logic [191:0] newkey);
        logic [127:0] pa, pb, got;
        pa = {$urandom, $urandom, $urandom, $urandom};
        pb = {$urandom, $urandom, $urandom, $urandom};
        step();
        din_en = 1'b1;
        pt_in = pa;
        look();
        for (int i = 1; i <= 22; i++) begin
            step();
            din_en = 1'b0;
            look();
        end
        step();
        key_en = 1'b1;
        key_in = newkey;
        din_en = 1'b1;
        look();
        total++;
        if (o_round !== 4'd6 || o_col !== 2'd2 || o_load !== 1'b0) begin
            bad++;
            $display("FAIL abort_point: got r%0d c%0d load=%b want r6 c2 load=0", o_round, o_col, o_load);
        end
        for (int j = 1; j <= 30; j++) begin
            step();
            key_en = 1'b0;
            din_en = 1'b0;
            look();
            total++;
            if (o_round !== 4'd0 || o_col !== 2'd0 || o_dout_en !== 1'b0) begin
                bad++;
                $display("FAIL abort_cleared T+%0d: got r%0d c%0d dout=%b want 0 0 0", j, o_round, o_col, o_dout_en);
            end
            total++;
            if (o_busy !== (j <= 8) || o_din_ready !== (j >= 9)) begin
                bad++;
                $display("FAIL abort_rekey T+%0d: got busy=%b rdy=%b want %b %b", j, o_busy, o_din_ready, j <= 8, j >= 9);
            end
        end
        total++;
        if (ct_q.size() != 0) begin
            bad++;
            $display("FAIL abort_no_ct: got %0d want 0", ct_q.size());
        end
        step();
        din_en = 1'b1;
        pt_in = pb;
        look();
        for (int i = 1; i <= 49; i++) begin
            step();
            din_en = 1'b0;
            look();
        end
        total++;
        if (o_dout_en !== 1'b1 || ct_q.size() != 1) begin
            bad++;
            $display("FAIL abort_newkey_dout: got dout=%b n=%0d want 1 1", o_dout_en, ct_q.size());
        end else begin
            got = ct_q.pop_front();
            total++;
            if (got !== aes_encrypt(key_expand(newkey), pb)) begin
                bad++;
                $display("FAIL abort_newkey_ct: got %h want %h", got, aes_encrypt(key_expand(newkey), pb));
            end
        end
        ct_q.delete();
    endtask

    task automatic test_reset_mid();
        step();
        din_en = 1'b1;
        pt_in = {$urandom, $urandom, $urandom, $urandom};
        look();
        for (int i = 1; i <= 10; i++) begin
            step();
            din_en = 1'b0;
            look();
        end
        total++;
        if (o_round !== 4'd3) begin
            bad++;
            $display("FAIL rstmid_round: got %0d want 3", o_round);
        end
        rst = 1'b1;
        din_en = 1'b1;
        #1;
        total++;
        if ({o_busy, o_din_ready, o_load, o_round_end, o_last_round, o_dout_en, o_round, o_col} !== 12'h0) begin
            bad++;
            $display("FAIL rstmid_immediate: got %h want 000",
                     {o_busy, o_din_ready, o_load, o_round_end, o_last_round, o_dout_en, o_round, o_col});
        end
        step();
        rst = 1'b0;
        for (int j = 1; j <= 60; j++) begin
            step();
            look();
            total++;
            if ({o_busy, o_din_ready, o_load, o_dout_en} !== 4'b0) begin
                bad++;
                $display("FAIL rstmid_ignored j=%0d: got busy/rdy/load/dout=%b want 0000", j,
                         {o_busy, o_din_ready, o_load, o_dout_en});
            end
        end
        din_en = 1'b0;
        total++;
        if (ct_q.size() != 0) begin
            bad++;
            $display("FAIL rstmid_no_ct: got %0d want 0", ct_q.size());
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        logic [191:0] k2;
        k2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        test_reset();
        test_keyload(FIPS_KEY);
        test_fips();
        test_back_to_back(FIPS_KEY);
        test_random(FIPS_KEY);
        test_abort(k2);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes192_ctrl.md
# aes192_ctrl

Sequencer and S-box arbiter for the AES-192 encryption core. It starts key expansion on the `aes192_keyex` block and holds off data until `key_ok`. It then steps the column-serial round datapath through NR rounds of four S-box column cycles each. It multiplexes the single shared 32-bit S-box bank between key expansion (priority) and the round datapath.

## Interface
- NR, 12, number of rounds; legal 10/12/14; round counter is 4 bits
- i_clk  in  1  clock
- i_rst  in  1  reset i_rst, asynchronous, active-high; clock i_clk
- i_key_en  in  1  key-load pulse; key presented to keyex in the same cycle
- o_kx_key_en  out  1  to keyex i_key_en; equals i_key_en (combinational)
- i_kx_key_ok  in  1  keyex o_key_ok
- i_kx_sbox_use  in  1  keyex o_sbox_use
- i_kx_sbox_din  in  32  keyex o_sbox_din
- i_rd_sbox_din  in  32  round datapath column to substitute
- o_sbox_din  out  32  to shared S-box bank; S-box dout is fanned out directly to both clients
- i_din_en  in  1  plaintext valid
- o_din_ready  out  1  block may be accepted this cycle
- o_load  out  1  datapath loads state = din ^ round key 0
- o_round  out  4  current round 1..NR; selects the round key slice
- o_col  out  2  current column 0..3
- o_round_end  out  1  column 3 of a round; datapath commits MixColumns/AddRoundKey
- o_last_round  out  1  o_round==NR; MixColumns skipped
- o_dout_en  out  1  ciphertext valid pulse
- o_busy  out  1  state is KEYEX or RUN

## Operation
- States: IDLE (no valid key), KEYEX, READY, RUN.
- i_key_en in any state -> KEYEX next cycle. An in-flight block is aborted: no o_dout_en, round/col cleared.
- KEYEX and i_kx_key_ok=1 and i_key_en=0 -> READY.
- READY and o_load -> RUN with round=1, col=0.
- RUN: col increments each cycle. At col=3, round increments and col wraps to 0. At round=NR, col=3 -> READY, and o_dout_en pulses in the following cycle.
- o_din_ready = (state==READY) & ~i_key_en. o_load = i_din_en & o_din_ready. i_din_en while not ready is ignored and not queued.
- S-box mux: o_sbox_din = i_kx_sbox_use ? i_kx_sbox_din : i_rd_sbox_din.
  - Key expansion always wins.
  - The round datapath never drives a meaningful column while keyex is busy, because i_key_en aborts RUN.
- o_round_end = (state==RUN) & (col==3). o_last_round = (state==RUN) & (round==NR).
- Outside RUN: o_round=0 and o_col=0.

## Timing
- Reset values: state IDLE; o_round 0, o_col 0; o_din_ready, o_load, o_round_end, o_last_round, o_dout_en, o_busy all 0. o_sbox_din follows the mux.
- Key: i_key_en at cycle T. Keyex owns the S-box for T..T+7 and key_ok rises at T+8. State is KEYEX from T+1, READY from T+9. First o_din_ready=1 at T+9.
- Block: o_load at cycle D.
  - RUN covers D+1..D+4·NR; for NR=12 that is D+1..D+48.
  - o_round=r, o_col=c at cycle D+4(r−1)+c+1.
  - o_dout_en=1 at D+4·NR+1 (D+49), with state READY.
  - o_din_ready=1 in the same cycle, so back-to-back blocks are accepted with a 4·NR+1 cycle period.
- i_key_en coinciding with i_din_en: key wins and o_load=0.
- i_key_en during KEYEX: keyex restarts and key_ok must be re-observed, so READY is reached 9 cycles after the latest i_key_en.
- Async reset mid-RUN or mid-KEYEX: immediate return to IDLE and all outputs at reset values. Only a new i_key_en leaves IDLE.

## Test plan
- Reset, then hold i_din_en=1 with no key -> o_din_ready stays 0, no o_load, state IDLE.
- i_key_en at T=10 -> o_busy 1 for T+1..T+8, o_din_ready first 1 at cycle 19. o_sbox_din = i_kx_sbox_din at T..T+7 (drive i_kx_sbox_din=32'hA5A5_0000, i_rd_sbox_din=32'h0000_5A5A).
- FIPS-197 C.2 vector with key 000102..1617 and plaintext 00112233..eeff, through the full core -> ciphertext dda97ca4864cdfe06eaf70a0ec0d7191. o_dout_en exactly 49 cycles after o_load; o_round_end pulses 12 times; o_last_round high for 4 cycles.
- Back-to-back: re-assert i_din_en in the o_dout_en cycle -> o_load in that same cycle and a second correct ciphertext 49 cycles later.
- i_key_en at round 6, col 2 -> no o_dout_en, o_round=0 next cycle, READY 9 cycles later; a subsequent block encrypts under the new key.
- Async reset at round 3 -> all outputs 0 immediately. A later i_din_en without a new key is ignored.
